// File: rtl/bpu_bimodal_btb.sv
// Bimodal branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters.
// Optional BPU_STATS_EN adds resolved-control and mispredict counters.
module bpu_bimodal_btb #(
   parameter int ENTRIES = 64,
   parameter int XLEN    = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [XLEN-1:0] i_if_pc,
   output logic            o_pred_hit,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_next_pc,
   input  logic            i_ex_vld,
   input  logic [XLEN-1:0] i_ex_pc,
   input  logic            i_ex_is_br,
   input  logic            i_ex_is_jmp,
   input  logic            i_ex_taken,
   input  logic [XLEN-1:0] i_ex_target,
   input  logic [XLEN-1:0] i_ex_pred_next_pc,
   output logic            o_mispred,
   output logic            o_flush,
   output logic [XLEN-1:0] o_redirect_pc
`ifdef BPU_STATS_EN
   ,
   output logic [31:0]     o_stat_ctl,
   output logic [31:0]     o_stat_mis
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [ENTRIES-1:0] tbl_valid;
   logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
   logic [XLEN-1:0]    tbl_target [ENTRIES];
   logic [1:0]         tbl_ctr    [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic [XLEN-1:0]  ex_actual;

   always_comb begin
      if_idx         = i_if_pc[IDX_W+1:2];
      if_tag         = i_if_pc[XLEN-1:IDX_W+2];
      o_pred_hit     = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
      o_pred_taken   = o_pred_hit && tbl_ctr[if_idx][1];
      o_pred_next_pc = o_pred_taken ? tbl_target[if_idx] : i_if_pc + XLEN'(4);
   end

   always_comb begin
      ex_idx        = i_ex_pc[IDX_W+1:2];
      ex_tag        = i_ex_pc[XLEN-1:IDX_W+2];
      ex_hit        = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
      ex_actual     = i_ex_taken ? i_ex_target : i_ex_pc + XLEN'(4);
      o_mispred     = i_ex_vld && (ex_actual != i_ex_pred_next_pc);
      o_flush       = o_mispred;
      o_redirect_pc = ex_actual;
   end

   // Training: jumps take priority over branches when both flags are set.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tbl_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_ctr[i] <= 2'b01;
         end
      end else if (i_ex_vld) begin
         if (i_ex_is_jmp) begin
            if (ex_hit || i_ex_taken) begin
               tbl_valid[ex_idx]  <= 1'b1;
               tbl_tag[ex_idx]    <= ex_tag;
               tbl_target[ex_idx] <= i_ex_target;
               tbl_ctr[ex_idx]    <= 2'b11;
            end
         end else if (i_ex_is_br) begin
            if (ex_hit) begin
               if (i_ex_taken) begin
                  tbl_target[ex_idx] <= i_ex_target;
                  if (tbl_ctr[ex_idx] != 2'b11) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 2'b01;
               end else if (tbl_ctr[ex_idx] != 2'b00) begin
                  tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 2'b01;
               end
            end else if (i_ex_taken) begin
               tbl_valid[ex_idx]  <= 1'b1;
               tbl_tag[ex_idx]    <= ex_tag;
               tbl_target[ex_idx] <= i_ex_target;
               tbl_ctr[ex_idx]    <= 2'b10;
            end
         end else if (ex_hit) begin
            // A non-control instruction aliasing into the table kills the stale entry.
            tbl_valid[ex_idx] <= 1'b0;
         end
      end
   end

`ifdef BPU_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_stat_ctl <= '0;
         o_stat_mis <= '0;
      end else begin
         if (i_ex_vld && (i_ex_is_br || i_ex_is_jmp)) o_stat_ctl <= o_stat_ctl + 32'd1;
         if (o_mispred) o_stat_mis <= o_stat_mis + 32'd1;
      end
   end
`endif

endmodule

// File: doc/bpu_bimodal_btb.md
# bpu_bimodal_btb

Parametrised dynamic branch predictor replacing the static always-taken scheme in the five-stage pipeline. Combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. Predicts next PC in IF from the fetch PC, resolves and trains from EX, and generates mispredict/flush/redirect. Feeds the IF PC mux and the IF/ID and ID/EX flush inputs.

## Interface
- ENTRIES, 64, BTB/counter entries; power of two, 4..1024; IDX_W = log2(ENTRIES)
- XLEN, 32, PC/target width; TAG_W = XLEN-IDX_W-2
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset; synchronous and active-high
- i_if_pc  in  XLEN  fetch PC (IF)
- o_pred_hit  out  1  valid entry with matching tag for i_if_pc
- o_pred_taken  out  1  predicted taken
- o_pred_next_pc  out  XLEN  predicted next fetch PC
- i_ex_vld  in  1  valid instruction in EX (not flushed)
- i_ex_pc  in  XLEN  PC of EX instruction
- i_ex_is_br  in  1  conditional branch
- i_ex_is_jmp  in  1  JAL/JALR
- i_ex_taken  in  1  resolved direction (1 for jumps)
- i_ex_target  in  XLEN  resolved target (ALU result)
- i_ex_pred_next_pc  in  XLEN  o_pred_next_pc carried down pipe for this instruction
- o_mispred  out  1  EX prediction wrong
- o_flush  out  1  flush IF/ID and ID/EX; equals o_mispred
- o_redirect_pc  out  XLEN  correct next PC; valid when o_mispred
- o_stat_ctl  out  32  resolved control instructions (only with BPU_STATS_EN)
- o_stat_mis  out  32  mispredicts (only with BPU_STATS_EN)

## Operation
- Entry: valid, tag[TAG_W], target[XLEN], ctr[2]. idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup: hit = valid && tag match. o_pred_taken = hit && ctr[1]. o_pred_next_pc = o_pred_taken ? target : i_if_pc+4 (mod 2^XLEN).
- Resolve (i_ex_vld=1): actual = i_ex_taken ? i_ex_target : i_ex_pc+4. o_mispred = (actual != i_ex_pred_next_pc). o_redirect_pc = actual. i_ex_vld=0 forces o_mispred=0, no update.
- Train, entry at EX idx, hit = valid && tag(i_ex_pc) match:
  - branch, hit: ctr saturating +1 if taken else -1 (00 and 11 stick); target written when taken.
  - jump, hit: ctr=11, target written.
  - branch/jump miss, taken: allocate (overwrite): valid=1, tag, target; ctr=10 (branch) or 11 (jump).
  - branch miss, not taken: no write.
  - non-control instruction, hit (alias): valid cleared.
- i_ex_is_br and i_ex_is_jmp both 1: treated as jump.

## Timing
- Lookup and resolve outputs combinational (0-cycle) from current inputs and table state.
- Training writes at i_clk rising edge while i_ex_vld=1; visible to lookup next cycle.
- Same-cycle lookup and update of the same idx: lookup returns pre-update contents; no bypass.
- Reset: with i_reset=1 at an edge, all valid=0, ctr=01, stat counters=0; pending update that cycle dropped. Outputs after reset: o_pred_hit=0, o_pred_taken=0, o_pred_next_pc=i_if_pc+4, o_mispred=o_flush=0 while i_ex_vld=0.
- Reset asserted mid-run takes priority over any update; table usable the following cycle.

## Configuration
- BPU_STATS_EN defined: o_stat_ctl increments on each cycle with i_ex_vld && (i_ex_is_br||i_ex_is_jmp); o_stat_mis on each cycle with o_mispred=1; 32-bit, wrap 0xFFFFFFFF->0, reset 0.
- Undefined: stat ports and counters absent; predictor behaviour identical.

## Test plan
- ENTRIES=64. Reset, i_if_pc=0x100 -> hit=0, taken=0, next=0x104.
- EX branch pc=0x100, taken, target=0x80, pred_next=0x104 -> o_mispred=1, o_flush=1, redirect=0x80; next cycle i_if_pc=0x100 -> hit=1, taken=1, next=0x80.
- Then EX same branch not taken, pred_next=0x80 -> mispred=1, redirect=0x104; ctr 10->01; lookup 0x100 -> taken=0, next=0x104; two more not-taken keep ctr=00; one taken -> 01 still not-taken.
- Alias: entry for 0x100 present, i_if_pc=0x200 (same idx 0) -> hit=0; EX jump pc=0x200 target=0x40 -> entry replaced, lookup 0x100 misses; EX non-control pc=0x200 -> entry invalidated.
- Same cycle: EX trains 0x100 taken->0x80 while i_if_pc=0x100 -> lookup still old (miss, next 0x104); next cycle hit, next 0x80. Reset asserted same cycle as update -> lookup 0x100 misses afterwards.
- BPU_STATS_EN: 5 resolved branches, 2 mispredicted -> o_stat_ctl=5, o_stat_mis=2; preload counters to 0xFFFFFFFF then one event -> 0.
